// File: rtl/regram_burst_mover.sv
// regram_burst_mover
//   RAM plus register file with a command-driven burst transfer engine.
//   A command moves 1..RF_DEPTH words either RAM->RF (LOAD) or RF->RAM
//   (STORE). Two combinational RF read ports serve the ALU side, and a host
//   write port can update the RF while the engine is idle.
//
// Ports
//   Clock, Reset_n                   system clock, async active-low reset
//   Cmd_Valid/Cmd_Ready              command handshake (Ready only when idle)
//   Cmd_Op                           0 = LOAD (RAM->RF), 1 = STORE (RF->RAM)
//   Cmd_DAddr, Cmd_RAddr, Cmd_Len    RAM start, RF start, burst length - 1
//   Done                             one-cycle pulse at burst completion
//   Host_W_En/Addr/Data              host RF write, honoured only when idle
//   Ra_Addr/Ra_Data, Rb_Addr/Rb_Data combinational RF read ports
//
// State table
//   state   | meaning
//   S_IDLE  | ready for a command, host writes allowed
//   S_LOAD  | issuing RAM reads, one word per cycle
//   S_DRAIN | last RAM word in flight, final RF write
//   S_STORE | writing RF words into RAM, one per cycle
//   S_DONE  | Done pulse, back to idle next cycle

module regram_burst_mover #(
    parameter int DATA_W    = 16,
    parameter int RF_DEPTH  = 16,
    parameter int RAM_DEPTH = 256,
    localparam int RF_AW    = $clog2(RF_DEPTH),
    localparam int RAM_AW   = $clog2(RAM_DEPTH)
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              Cmd_Valid,
    output logic              Cmd_Ready,
    input  logic              Cmd_Op,
    input  logic [RAM_AW-1:0] Cmd_DAddr,
    input  logic [RF_AW-1:0]  Cmd_RAddr,
    input  logic [RF_AW-1:0]  Cmd_Len,
    output logic              Done,
    input  logic              Host_W_En,
    input  logic [RF_AW-1:0]  Host_W_Addr,
    input  logic [DATA_W-1:0] Host_W_Data,
    input  logic [RF_AW-1:0]  Ra_Addr,
    input  logic [RF_AW-1:0]  Rb_Addr,
    output logic [DATA_W-1:0] Ra_Data,
    output logic [DATA_W-1:0] Rb_Data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_STORE,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [RAM_AW-1:0] dptr;
    logic [RF_AW-1:0]  rptr;
    logic [RF_AW-1:0]  cnt;
    logic [RF_AW-1:0]  rptr_d;
    logic              ld_vld;
    logic [DATA_W-1:0] ram_q;
    logic [DATA_W-1:0] ram_mem [RAM_DEPTH];
    logic [DATA_W-1:0] rf      [RF_DEPTH];
    logic              accept;
    logic              moving;

    assign accept = Cmd_Valid & Cmd_Ready;
    assign moving = (state == S_LOAD) || (state == S_STORE);

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        Cmd_Ready = 1'b0;
        Done      = 1'b0;
        case (state)
            S_IDLE: begin
                Cmd_Ready = 1'b1;
                if (Cmd_Valid) begin
                    state_nxt = Cmd_Op ? S_STORE : S_LOAD;
                end
            end
            S_LOAD: begin
                if (cnt == '0) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                state_nxt = S_DONE;
            end
            S_STORE: begin
                if (cnt == '0) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                Done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Pointers wrap naturally at their widths; the count is free to wrap on
    // the final beat because the FSM leaves the moving state at the same edge.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            dptr   <= '0;
            rptr   <= '0;
            cnt    <= '0;
            rptr_d <= '0;
            ld_vld <= 1'b0;
        end else begin
            if (accept) begin
                dptr <= Cmd_DAddr;
                rptr <= Cmd_RAddr;
                cnt  <= Cmd_Len;
            end else if (moving) begin
                dptr <= dptr + RAM_AW'(1);
                rptr <= rptr + RF_AW'(1);
                cnt  <= cnt - RF_AW'(1);
            end
            // RAM read data arrives one edge after the issue; the valid bit
            // and the RF pointer travel alongside it.
            ld_vld <= (state == S_LOAD);
            rptr_d <= rptr;
        end
    end

    // RAM is not reset; the non-blocking read gives old data on a
    // same-address write.
    always_ff @(posedge Clock) begin
        if (state == S_STORE) begin
            ram_mem[dptr] <= rf[rptr];
        end
        ram_q <= ram_mem[dptr];
    end

    // Pipeline writes and host writes never coincide: ld_vld is only high
    // in LOAD/DRAIN, host writes only land in IDLE.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < RF_DEPTH; i++) begin
                rf[i] <= '0;
            end
        end else if (ld_vld) begin
            rf[rptr_d] <= ram_q;
        end else if ((state == S_IDLE) && Host_W_En) begin
            rf[Host_W_Addr] <= Host_W_Data;
        end
    end

    assign Ra_Data = rf[Ra_Addr];
    assign Rb_Data = rf[Rb_Addr];

endmodule

// File: tb/tb_regram_burst_mover.sv
// Self-checking bench for regram_burst_mover. A reference model of the RAM
// and RF is updated as commands are issued; expected Done latencies and RF
// contents go into scoreboard queues and are popped as the DUT answers.
`timescale 1ns/1ps

module tb_regram_burst_mover;

    localparam int DATA_W = 16;
    localparam int RF_AW  = 4;
    localparam int RAM_AW = 8;

    logic              Clock;
    logic              Reset_n;
    logic              Cmd_Valid;
    logic              Cmd_Ready;
    logic              Cmd_Op;
    logic [RAM_AW-1:0] Cmd_DAddr;
    logic [RF_AW-1:0]  Cmd_RAddr;
    logic [RF_AW-1:0]  Cmd_Len;
    logic              Done;
    logic              Host_W_En;
    logic [RF_AW-1:0]  Host_W_Addr;
    logic [DATA_W-1:0] Host_W_Data;
    logic [RF_AW-1:0]  Ra_Addr;
    logic [RF_AW-1:0]  Rb_Addr;
    logic [DATA_W-1:0] Ra_Data;
    logic [DATA_W-1:0] Rb_Data;

    regram_burst_mover #(
        .DATA_W   (16),
        .RF_DEPTH (16),
        .RAM_DEPTH(256)
    ) dut (
        .Clock       (Clock),
        .Reset_n     (Reset_n),
        .Cmd_Valid   (Cmd_Valid),
        .Cmd_Ready   (Cmd_Ready),
        .Cmd_Op      (Cmd_Op),
        .Cmd_DAddr   (Cmd_DAddr),
        .Cmd_RAddr   (Cmd_RAddr),
        .Cmd_Len     (Cmd_Len),
        .Done        (Done),
        .Host_W_En   (Host_W_En),
        .Host_W_Addr (Host_W_Addr),
        .Host_W_Data (Host_W_Data),
        .Ra_Addr     (Ra_Addr),
        .Rb_Addr     (Rb_Addr),
        .Ra_Data     (Ra_Data),
        .Rb_Data     (Rb_Data)
    );

    initial Clock = 1'b0;
    always #10 Clock = ~Clock;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] mram [256];
    logic [15:0] mrf  [16];
    int          exp_lat [$];
    logic [15:0] exp_rf  [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic host_wr(input logic [3:0] a, input logic [15:0] d);
        @(negedge Clock);
        Host_W_En   = 1'b1;
        Host_W_Addr = a;
        Host_W_Data = d;
        @(negedge Clock);
        Host_W_En   = 1'b0;
        mrf[a]      = d;
    endtask

    // Reads all 16 registers through both ports within the low clock phase.
    task automatic rf_check(input string tag);
        logic [15:0] e;
        for (int i = 0; i < 16; i++) exp_rf.push_back(mrf[i]);
        @(negedge Clock);
        for (int i = 0; i < 8; i++) begin
            Ra_Addr = 4'(2 * i);
            Rb_Addr = 4'(2 * i + 1);
            #1;
            e = exp_rf.pop_front();
            check({tag, "_ra"}, Ra_Data, e);
            e = exp_rf.pop_front();
            check({tag, "_rb"}, Rb_Data, e);
        end
    endtask

    // Issues one command and watches Done for a bounded window.
    // inj_cyc: cycle to pulse a competing command + host write (0 = none).
    // rst_cyc: cycle to assert reset for two cycles (0 = none).
    task automatic run_cmd(input logic op, input logic [7:0] daddr, input logic [3:0] raddr,
                           input logic [3:0] len, input int inj_cyc, input int rst_cyc);
        int ndone;
        int exp_n;
        int win;
        ndone = 0;
        win   = int'(len) + 12;
        exp_n = (rst_cyc == 0) ? 1 : 0;
        if (rst_cyc == 0) begin
            for (int i = 0; i <= int'(len); i++) begin
                if (op) mram[8'(int'(daddr) + i)] = mrf[4'(int'(raddr) + i)];
                else    mrf[4'(int'(raddr) + i)]  = mram[8'(int'(daddr) + i)];
            end
            exp_lat.push_back(op ? int'(len) + 2 : int'(len) + 3);
        end
        @(negedge Clock);
        Cmd_Valid = 1'b1;
        Cmd_Op    = op;
        Cmd_DAddr = daddr;
        Cmd_RAddr = raddr;
        Cmd_Len   = len;
        @(posedge Clock);
        for (int cyc = 1; cyc <= win; cyc++) begin
            @(negedge Clock);
            if (Done) begin
                ndone++;
                if (exp_lat.size() > 0) check("done_lat", cyc, exp_lat.pop_front());
                else                    check("done_spurious", Done, 0);
            end
            if (cyc == 1) begin
                Cmd_Valid = 1'b0;
                check("ready_busy", Cmd_Ready, 0);
            end
            if (inj_cyc != 0 && cyc == inj_cyc) begin
                check("ready_inj", Cmd_Ready, 0);
                Cmd_Valid   = 1'b1;
                Cmd_Op      = 1'b1;
                Host_W_En   = 1'b1;
                Host_W_Addr = 4'd5;
                Host_W_Data = 16'hDEAD;
            end
            if (inj_cyc != 0 && cyc == inj_cyc + 1) begin
                Cmd_Valid = 1'b0;
                Host_W_En = 1'b0;
            end
            if (rst_cyc != 0 && cyc == rst_cyc) begin
                Reset_n = 1'b0;
                for (int i = 0; i < 16; i++) mrf[i] = '0;
            end
            if (rst_cyc != 0 && cyc == rst_cyc + 2) Reset_n = 1'b1;
        end
        check("done_count", ndone, exp_n);
        exp_lat.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] sum;
        Reset_n     = 1'b0;
        Cmd_Valid   = 1'b0;
        Cmd_Op      = 1'b0;
        Cmd_DAddr   = '0;
        Cmd_RAddr   = '0;
        Cmd_Len     = '0;
        Host_W_En   = 1'b0;
        Host_W_Addr = '0;
        Host_W_Data = '0;
        Ra_Addr     = '0;
        Rb_Addr     = '0;
        for (int i = 0; i < 16; i++) mrf[i] = '0;
        for (int i = 0; i < 256; i++) mram[i] = 'x;
        repeat (3) @(negedge Clock);
        Reset_n = 1'b1;

        // Asynchronous reset observed without a clock edge
        host_wr(4'd1, 16'h5555);
        host_wr(4'd14, 16'h7777);
        @(posedge Clock);
        #3;
        Reset_n = 1'b0;
        #1;
        check("rst_ready", Cmd_Ready, 1);
        check("rst_done", Done, 0);
        for (int i = 0; i < 8; i++) begin
            Ra_Addr = 4'(2 * i);
            Rb_Addr = 4'(2 * i + 1);
            #0.5;
            check("rst_rf_a", Ra_Data, 0);
            check("rst_rf_b", Rb_Data, 0);
        end
        for (int i = 0; i < 16; i++) mrf[i] = '0;
        @(negedge Clock);
        Reset_n = 1'b1;

        // Host writes then STORE
        host_wr(4'd2, 16'h1234);
        host_wr(4'd3, 16'hABCD);
        run_cmd(1'b1, 8'h10, 4'd2, 4'd1, 0, 0);

        // LOAD back to RF[0..1]
        run_cmd(1'b0, 8'h10, 4'd0, 4'd1, 0, 0);
        @(negedge Clock);
        Ra_Addr = 4'd0;
        Rb_Addr = 4'd1;
        #1;
        check("ld_ra", Ra_Data, 16'h1234);
        check("ld_rb", Rb_Data, 16'hABCD);
        sum = Ra_Data + Rb_Data;
        check("ld_sum", sum, 16'hBE01);
        rf_check("ld_rf");

        // Wrap on both pointers, then read back through a LOAD that wraps
        host_wr(4'd15, 16'h0007);
        host_wr(4'd0, 16'h0009);
        run_cmd(1'b1, 8'hFF, 4'd15, 4'd1, 0, 0);
        run_cmd(1'b0, 8'hFF, 4'd4, 4'd1, 0, 0);
        rf_check("wrap_rf");

        // Busy: competing command and host write during a 16-word LOAD
        for (int i = 0; i < 16; i++) host_wr(4'(i), 16'(16'h1000 + i * 16'h0111));
        run_cmd(1'b1, 8'h40, 4'd0, 4'd15, 0, 0);
        run_cmd(1'b0, 8'h40, 4'd8, 4'd15, 3, 0);
        check("busy_rf5_model", mrf[5], 16'h1DDD);
        rf_check("busy_rf");

        // Reset mid-burst
        run_cmd(1'b0, 8'h40, 4'd0, 4'd7, 0, 3);
        @(negedge Clock);
        check("rst_mid_ready", Cmd_Ready, 1);
        rf_check("rst_mid_rf");
        run_cmd(1'b0, 8'h10, 4'd0, 4'd0, 0, 0);
        rf_check("post_rst_rf");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/regram_burst_mover.md
Name: regram_burst_mover

Overview:
Parametrised RAM + register-file datapath with a command-driven transfer engine.
- Moves bursts of 1..RF_DEPTH words RAM->RF (LOAD) or RF->RAM (STORE) under a valid/ready command handshake.
- Keeps two combinational RF read ports for the ALU side.
- Successor to the fixed 16-bit, single-word RAM-to-RF path: it adds width/depth parameters, bursts, the STORE direction, reset, and a host write port.

Parameters:
DATA_W, 16, word width of RAM and RF
RF_DEPTH, 16, number of RF registers (power of 2); RF_AW = log2(RF_DEPTH)
RAM_DEPTH, 256, number of RAM words (power of 2); RAM_AW = log2(RAM_DEPTH)

Ports:
Clock  in  1  system clock, rising edge
Reset_n  in  1  asynchronous active-low reset
Cmd_Valid  in  1  command request
Cmd_Ready  out  1  engine idle, command accepted when Valid&Ready at posedge
Cmd_Op  in  1  0=LOAD (RAM->RF), 1=STORE (RF->RAM)
Cmd_DAddr  in  RAM_AW  RAM start address
Cmd_RAddr  in  RF_AW  RF start register
Cmd_Len  in  RF_AW  burst length minus 1 (0 => 1 word)
Done  out  1  one-cycle pulse at burst completion
Host_W_En  in  1  host RF write enable, honoured only when Cmd_Ready=1
Host_W_Addr  in  RF_AW  host RF write address
Host_W_Data  in  DATA_W  host RF write data
Ra_Addr  in  RF_AW  A-side read address
Rb_Addr  in  RF_AW  B-side read address
Ra_Data  out  DATA_W  RF[Ra_Addr], combinational
Rb_Data  out  DATA_W  RF[Rb_Addr], combinational

Behaviour:
- Reset (async, Reset_n=0):
  - FSM goes to IDLE; counters and pointers are cleared.
  - All RF registers are cleared to 0; Done=0; Cmd_Ready=1 after release.
  - RAM contents are not cleared.
  - Reset mid-burst aborts it: RF/RAM words already written stay written, except that the RF is cleared. No Done pulse.
- RAM: synchronous, one write port and one read port. The address is registered, so q is valid one cycle after the address is presented. Read-during-write to the same address returns old data.
- RF: writes are synchronous; reads are combinational. A read during a write to the same register returns the old value until the edge.
- FSM states: IDLE, LOAD, DRAIN, STORE, DONE. Cmd_Ready=1 only in IDLE.
- IDLE:
  - On Valid&Ready, latch dptr=Cmd_DAddr, rptr=Cmd_RAddr, cnt=Cmd_Len.
  - Go to LOAD (Op=0) or STORE (Op=1).
  - Cmd_Valid outside IDLE is ignored (not queued).
- LOAD:
  - Each cycle, present dptr to RAM, then dptr++ and cnt--.
  - A 1-bit valid pipe plus a delayed rptr write RF[rptr_d] <= q one edge later.
  - After Len+1 issue cycles, go to DRAIN.
  - DRAIN performs the final RF write, then goes to DONE.
- STORE: each cycle write RAM[dptr] <= RF[rptr], then dptr++, rptr++, cnt--. After Len+1 cycles go to DONE.
- DONE: Done=1 for exactly one cycle, then IDLE.
- Latency from the accept edge to Done high: LOAD = Len+3 cycles; STORE = Len+2 cycles.
- Wrap-around: dptr wraps modulo RAM_DEPTH and rptr wraps modulo RF_DEPTH, with no error flag.
- Host write:
  - Host_W_En applies only in IDLE.
  - Host_W_En in the same cycle as command accept is still performed. The command's reads see the post-write RF because the first STORE read occurs in the next cycle.
  - Host_W_En while busy is dropped.
- Arithmetic: no data modification. Addresses are unsigned and truncate on overflow.

Test Plan:
- Reset: assert Reset_n=0 mid-cycle -> Cmd_Ready=1, Done=0, Ra_Data=Rb_Data=0 for all addresses, with no clock edge required.
- Host write then STORE: host writes RF[2]=16'h1234 and RF[3]=16'hABCD; STORE DAddr=8'h10, RAddr=2, Len=1 -> Done on the 3rd cycle after accept; RAM[0x10]=0x1234, RAM[0x11]=0xABCD.
- LOAD burst: after the previous test, LOAD DAddr=8'h10, RAddr=4'd0, Len=1 -> Done on the 4th cycle after accept; Ra_Addr=0 gives 0x1234, Rb_Addr=1 gives 0xABCD; the bench's sum of the two equals 16'hBE01.
- Wrap: STORE DAddr=8'hFF, RAddr=4'd15, Len=1 with RF[15]=7 and RF[0]=9 -> RAM[0xFF]=7 and RAM[0x00]=9; a later LOAD confirms both.
- Busy ignore: during a 16-word LOAD (Len=15), pulse Cmd_Valid with STORE and Host_W_En to RF[5]=0xDEAD -> Cmd_Ready=0; no second Done; RF[5] holds the loaded value, not 0xDEAD.
- Reset mid-burst: assert Reset_n low 3 cycles into a Len=7 LOAD -> no Done; after release Cmd_Ready=1 and all RF=0; a new LOAD of Len=0 completes with Done at cycle 3.
